vx_commit_arb: RTL and testbench

- Parametrised commit-side collector for the execute stage.
- Takes NUM_REQS independent functional-unit commit channels (alu, ld, st, csr, fpu, gpu, and future units) and buffers each in a per-channel FIFO.
- Merges the channels onto one registered writeback stream using fair round-robin arbitration with full valid/ready backpressure.
- Generalises the fixed six-port commit fan-out to any channel count, payload width and buffer depth, and adds flow control and a busy indication.

---
 rtl/vx_commit_arb.sv | 142 ++++++++++++++
 tb/tb_vx_commit_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: per-channel commit FIFOs merged onto one registered round-robin writeback stream.
// Optional feature macro: COMMIT_ARB_PERF_EN adds saturating stall/contention counters.
module vx_commit_arb #(
    parameter int NUM_REQS  = 6,
    parameter int DATAW     = 128,
    parameter int BUF_DEPTH = 2,
    parameter int SELW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out,
    output logic                      busy
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [43:0]               perf_stall_cycles,
    output logic [43:0]               perf_contention_cycles
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_REQS-1:0] w_full;
    logic [NUM_REQS-1:0] w_nempty;
    logic [NUM_REQS-1:0] w_push;
    logic [NUM_REQS-1:0] w_pop;
    logic [DATAW-1:0]    w_head [NUM_REQS];
    logic [DATAW-1:0]    w_gnt_data;
    logic [SELW-1:0]     w_gnt;
    logic                w_gnt_any;
    logic                w_load_en;
    logic                r_valid;
    logic [DATAW-1:0]    r_data;
    logic [SELW-1:0]     r_sel;

    assign ready_in  = ~w_full & {NUM_REQS{!reset}};
    assign w_push    = valid_in & ready_in;
    assign w_load_en = !r_valid || ready_out;
    assign w_pop     = (w_gnt_any && w_load_en) ? (NUM_REQS'(1) << w_gnt) : '0;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
        logic [DATAW-1:0] r_mem [BUF_DEPTH];
        logic [AW-1:0]    r_rd;
        logic [AW-1:0]    r_wr;
        logic [CW-1:0]    r_cnt;
        assign w_full[i]   = r_cnt == CW'(BUF_DEPTH);
        assign w_nempty[i] = r_cnt != '0;
        assign w_head[i]   = r_mem[r_rd];
        // Circular buffer; a full FIFO refuses pushes even when popped that cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[i]) begin
                    r_mem[r_wr] <= data_in[i*DATAW +: DATAW];
                    r_wr        <= r_wr + AW'(1);
                end
                if (w_pop[i])
                    r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push[i]) - CW'(w_pop[i]);
            end
        end
    end

    if (NUM_REQS == 1) begin : g_single
        assign w_gnt      = '0;
        assign w_gnt_any  = w_nempty[0];
        assign w_gnt_data = w_head[0];
    end else begin : g_rr
        logic [SELW-1:0] r_ptr;
        logic [SELW-1:0] w_idx;
        // First non-empty channel at or after the pointer; descending scan lets the nearest win.
        always_comb begin
            w_gnt     = '0;
            w_gnt_any = 1'b0;
            w_idx     = '0;
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                w_idx = SELW'((int'(r_ptr) + k) % NUM_REQS);
                if (w_nempty[w_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt     = w_idx;
                end
            end
        end
        assign w_gnt_data = w_head[w_gnt];
        // Pointer moves just past the granted channel.
        always_ff @(posedge clk) begin
            if (reset)
                r_ptr <= '0;
            else if (w_load_en && w_gnt_any)
                r_ptr <= (w_gnt == SELW'(NUM_REQS - 1)) ? '0 : w_gnt + SELW'(1);
        end
    end

    // Output register loads whenever it is empty or being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_load_en) begin
            r_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_data <= w_gnt_data;
                r_sel  <= w_gnt;
            end
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign sel_out   = r_sel;
    assign busy      = r_valid || (|w_nempty);

`ifdef COMMIT_ARB_PERF_EN
    logic [43:0] r_stall;
    logic [43:0] r_cont;
    logic        w_multi;
    assign w_multi = (w_nempty & (w_nempty - NUM_REQS'(1))) != '0;
    // Saturating stall and contention counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
            r_cont  <= '0;
        end else begin
            if (r_valid && !ready_out && !(&r_stall))
                r_stall <= r_stall + 44'd1;
            if (w_multi && !(&r_cont))
                r_cont <= r_cont + 44'd1;
        end
    end
    assign perf_stall_cycles      = r_stall;
    assign perf_contention_cycles = r_cont;
`endif
endmodule

// File: tb/tb_vx_commit_arb.sv
// tb_vx_commit_arb: directed self-checking bench for vx_commit_arb (default parameters).
module tb_vx_commit_arb;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [5:0]   valid_in = '0;
    logic [767:0] data_in = '0;
    logic [5:0]   ready_in;
    logic         valid_out;
    logic [127:0] data_out;
    logic [2:0]   sel_out;
    logic         ready_out = 1'b1;
    logic         busy;
`ifdef COMMIT_ARB_PERF_EN
    logic [43:0]  perf_stall_cycles;
    logic [43:0]  perf_contention_cycles;
`endif
    int n_cmp = 0;
    int n_err = 0;

    vx_commit_arb dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_out (ready_out),
        .busy      (busy)
`ifdef COMMIT_ARB_PERF_EN
        ,
        .perf_stall_cycles      (perf_stall_cycles),
        .perf_contention_cycles (perf_contention_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int nout;
        int e1;
        int seen4;
        logic acc;
        logic [2:0]   q_sel [32];
        logic [127:0] q_dat [32];

        // reset state
        step();
        step();
        chk("rst_ready_in", ready_in, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_sel", sel_out, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready_in", ready_in, 6'h3f);

        // single push on channel 3
        valid_in[3] = 1'b1;
        data_in[3*128 +: 128] = 128'hABCD;
        step();
        valid_in = '0;
        chk("t1_lat_valid", valid_out, 0);
        chk("t1_lat_busy", busy, 1);
        step();
        chk("t1_valid", valid_out, 1);
        chk("t1_data", data_out, 128'hABCD);
        chk("t1_sel", sel_out, 3);
        step();
        chk("t1_done_valid", valid_out, 0);
        chk("t1_done_busy", busy, 0);

        // two simultaneous rounds on all channels
        reset = 1'b1;
        step();
        reset = 1'b0;
        valid_in = 6'h3f;
        for (int i = 0; i < 6; i++) data_in[i*128 +: 128] = 128'(32'h100 + i);
        step();
        for (int i = 0; i < 6; i++) data_in[i*128 +: 128] = 128'(32'h200 + i);
        step();
        valid_in = '0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            chk("t2_valid", valid_out, 1);
            chk("t2_sel", sel_out, 128'(k % 6));
            chk("t2_data", data_out, 128'((k < 6 ? 32'h100 : 32'h200) + (k % 6)));
        end
        step();
        chk("t2_idle", valid_out, 0);

        // backpressure on channel 0
        ready_out = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            valid_in[0] = 1'b1;
            data_in[0 +: 128] = 128'(n);
            acc = ready_in[0];
            step();
            if (acc) n++;
            if (c == 5) chk("t3_mid_data", data_out, 0);
        end
        chk("t3_accepts", 128'(n), 3);
        chk("t3_ready_low", ready_in[0], 0);
        chk("t3_valid", valid_out, 1);
        chk("t3_data", data_out, 0);
        chk("t3_sel", sel_out, 0);
        valid_in = '0;
        ready_out = 1'b1;
        step();
        chk("t3_d1_valid", valid_out, 1);
        chk("t3_d1", data_out, 1);
        step();
        chk("t3_d2", data_out, 2);
        step();
        chk("t3_drain", valid_out, 0);

        // channel 1 streaming, channel 4 one-shot mid-stream
        n = 0;
        nout = 0;
        for (int c = 0; c < 20; c++) begin
            valid_in[1] = (n < 8);
            data_in[128 +: 128] = 128'(n);
            valid_in[4] = (c == 3);
            data_in[4*128 +: 128] = 128'h44;
            acc = ready_in[1] && valid_in[1];
            step();
            if (acc) n++;
            if (valid_out && nout < 32) begin
                q_sel[nout] = sel_out;
                q_dat[nout] = data_out;
                nout++;
            end
        end
        valid_in = '0;
        chk("t4_count", 128'(nout), 9);
        e1 = 0;
        seen4 = 0;
        for (int j = 0; j < nout; j++) begin
            if (q_sel[j] == 3'd4) begin
                seen4++;
                chk("t4_ch4_pos", 128'(j), 3);
                chk("t4_ch4_data", q_dat[j], 128'h44);
            end else begin
                chk("t4_ch1_sel", q_sel[j], 1);
                chk("t4_ch1_data", q_dat[j], 128'(e1));
                e1++;
            end
        end
        chk("t4_ch4_seen", 128'(seen4), 1);

        // reset with entries buffered
        ready_out = 1'b0;
        valid_in = 6'b100101;
        step();
        valid_in = '0;
        step();
        chk("t5_busy_pre", busy, 1);
        chk("t5_valid_pre", valid_out, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_ready_in", ready_in, 0);
        step();
        chk("t5_valid", valid_out, 0);
        chk("t5_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("t5_ready_in", ready_in, 6'h3f);
        ready_out = 1'b1;
        step();
        chk("t5_valid_after", valid_out, 0);
        chk("t5_busy_after", busy, 0);

`ifdef COMMIT_ARB_PERF_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        valid_in[0] = 1'b1;
        step();
        valid_in = '0;
        ready_out = 1'b0;
        step();
        for (int c = 0; c < 5; c++) step();
        ready_out = 1'b1;
        step();
        chk("p_stall", perf_stall_cycles, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ready_out = 1'b0;
        valid_in = 6'b000101;
        for (int c = 0; c < 8; c++) step();
        valid_in = '0;
        chk("p_contention_ge4", perf_contention_cycles >= 44'd4, 1);
        ready_out = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
